// File: rtl/alu_pkg.sv
// Shared types for the ALU command issuer.
// Operand/result widths, op codes, command bundle and issuer states.
package alu_pkg;

  localparam int OPND_W = 8;
  localparam int RES_W = 16;
  localparam int OP_W = 3;
  // Widest tag a command can carry; issuers use the low TAG_W bits.
  localparam int CMD_TAG_W = 8;

  typedef enum logic [OP_W-1:0] {
    ADD = 3'd0,
    SUB = 3'd1,
    MUL = 3'd2,
    DIV = 3'd3,
    AND = 3'd4,
    XOR = 3'd5
  } alu_op_e;

  typedef struct packed {
    logic [OPND_W-1:0]    a;
    logic [OPND_W-1:0]    b;
    logic [OP_W-1:0]      op;
    logic                 cin;
    logic [CMD_TAG_W-1:0] tag;
  } alu_cmd_t;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    WAIT,
    RESP
  } issue_state_e;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Circular command buffer with wrapping pointers.
// Push is refused when full, pop is ignored when empty.
module alu_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign rdata = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10: count <= count + 1'b1;
        2'b01: count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/alu_cmd_issuer.sv
// Feeds buffered commands to the registered ALU one at a time
// and returns each result with its tag on a response stream.
module alu_cmd_issuer
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [OPND_W-1:0]      cmd_a,
  input  logic [OPND_W-1:0]      cmd_b,
  input  logic [OP_W-1:0]        cmd_op,
  input  logic                   cmd_cin,
  input  logic [TAG_W-1:0]       cmd_tag,
  output logic [OPND_W-1:0]      alu_a,
  output logic [OPND_W-1:0]      alu_b,
  output logic [OP_W-1:0]        alu_op_code,
  output logic                   alu_c_in,
  input  logic [RES_W-1:0]       alu_result,
  input  logic                   alu_c_out,
  input  logic                   alu_z_flag,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [RES_W-1:0]       rsp_result,
  output logic                   rsp_c_out,
  output logic                   rsp_z_flag,
  output logic [TAG_W-1:0]       rsp_tag,
  output logic                   rsp_div0,
  output logic                   rsp_illegal,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   busy
);

  alu_cmd_t     wcmd;
  alu_cmd_t     head;
  logic         full;
  logic         empty;
  logic         pop;
  logic         capture;
  logic         done;
  issue_state_e state;
  issue_state_e state_d;
  logic [TAG_W-1:0] sh_tag;
  logic         sh_div0;
  logic         sh_ill;

  assign wcmd = '{
    a:   cmd_a,
    b:   cmd_b,
    op:  cmd_op,
    cin: cmd_cin,
    tag: CMD_TAG_W'(cmd_tag)
  };

  assign cmd_ready = !full;
  assign busy = (state != IDLE) || !empty;

  alu_cmd_fifo #(
    .DEPTH(DEPTH),
    .W($bits(alu_cmd_t))
  ) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(cmd_valid && cmd_ready),
    .wdata(wcmd),
    .pop(pop),
    .rdata(head),
    .count(fifo_count),
    .full(full),
    .empty(empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_d;
  end

  always_comb begin
    state_d = state;
    pop = 1'b0;
    capture = 1'b0;
    done = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          pop = 1'b1;
          state_d = DRIVE;
        end
      end
      DRIVE: state_d = WAIT;
      WAIT: begin
        capture = 1'b1;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          done = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ALU bus and shadow change only when a command is issued
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a <= '0;
      alu_b <= '0;
      alu_op_code <= '0;
      alu_c_in <= 1'b0;
      sh_tag <= '0;
      sh_div0 <= 1'b0;
      sh_ill <= 1'b0;
    end else if (pop) begin
      alu_a <= head.a;
      alu_b <= head.b;
      alu_op_code <= head.op;
      alu_c_in <= head.cin;
      sh_tag <= TAG_W'(head.tag);
      sh_div0 <= (head.op == DIV) && (head.b == '0);
      sh_ill <= (head.op[2:1] == 2'b11);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_result <= '0;
      rsp_c_out <= 1'b0;
      rsp_z_flag <= 1'b0;
      rsp_tag <= '0;
      rsp_div0 <= 1'b0;
      rsp_illegal <= 1'b0;
    end else if (capture) begin
      rsp_valid <= 1'b1;
      rsp_result <= alu_result;
      rsp_c_out <= alu_c_out;
      rsp_z_flag <= alu_z_flag;
      rsp_tag <= sh_tag;
      rsp_div0 <= sh_div0;
      rsp_illegal <= sh_ill;
    end else if (done) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Scoreboard bench for alu_cmd_issuer with a behavioural
// registered ALU attached to the issue bus.
module tb_alu_cmd_issuer;
  import alu_pkg::*;

  localparam int DEPTH = 4;
  localparam int TAG_W = 4;
  localparam int CW = $clog2(DEPTH) + 1;

  logic             clk;
  logic             rst_n;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [7:0]       cmd_a;
  logic [7:0]       cmd_b;
  logic [2:0]       cmd_op;
  logic             cmd_cin;
  logic [TAG_W-1:0] cmd_tag;
  logic [7:0]       alu_a;
  logic [7:0]       alu_b;
  logic [2:0]       alu_op_code;
  logic             alu_c_in;
  logic [15:0]      alu_result;
  logic             alu_c_out;
  logic             alu_z_flag;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [15:0]      rsp_result;
  logic             rsp_c_out;
  logic             rsp_z_flag;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_div0;
  logic             rsp_illegal;
  logic [CW-1:0]    fifo_count;
  logic             busy;

  int n_vec = 0;
  int n_err = 0;
  bit rnd_phase = 0;

  typedef struct packed {
    logic [15:0] res;
    logic        c;
    logic        z;
  } alu_out_t;

  typedef struct packed {
    logic [15:0]      res;
    logic             c;
    logic             z;
    logic [TAG_W-1:0] tag;
    logic             div0;
    logic             ill;
  } exp_t;

  exp_t q[$];

  alu_cmd_issuer #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .cmd_cin(cmd_cin), .cmd_tag(cmd_tag),
    .alu_a(alu_a), .alu_b(alu_b),
    .alu_op_code(alu_op_code), .alu_c_in(alu_c_in),
    .alu_result(alu_result), .alu_c_out(alu_c_out),
    .alu_z_flag(alu_z_flag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_c_out(rsp_c_out),
    .rsp_z_flag(rsp_z_flag), .rsp_tag(rsp_tag),
    .rsp_div0(rsp_div0), .rsp_illegal(rsp_illegal),
    .fifo_count(fifo_count), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic alu_out_t alu_ref(logic [7:0] a, logic [7:0] b,
                                       logic [2:0] op, logic cin);
    alu_out_t o;
    logic [8:0] s;
    o = '0;
    case (op)
      3'd0: begin
        s = {1'b0, a} + {1'b0, b} + {8'd0, cin};
        o.res = {7'd0, s};
        o.c = s[8];
      end
      3'd1: begin
        o.res = {8'd0, a} - {8'd0, b};
        o.c = (a < b);
      end
      3'd2: o.res = {8'd0, a} * {8'd0, b};
      3'd3: if (b != 0) o.res = {a % b, a / b};
      3'd4: o.res = {8'd0, a & b};
      3'd5: o.res = {8'd0, a ^ b};
      default: ;
    endcase
    o.z = (o.res == 16'd0);
    return o;
  endfunction

  // One-cycle registered ALU
  always @(posedge clk)
    {alu_result, alu_c_out, alu_z_flag} <=
      alu_ref(alu_a, alu_b, alu_op_code, alu_c_in);

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    alu_out_t o;
    if (rst_n) begin
      if (cmd_valid && cmd_ready) begin
        o = alu_ref(cmd_a, cmd_b, cmd_op, cmd_cin);
        e.res = o.res;
        e.c = o.c;
        e.z = o.z;
        e.tag = cmd_tag;
        e.div0 = (cmd_op == 3'd3) && (cmd_b == 8'd0);
        e.ill = (cmd_op >= 3'd6);
        q.push_back(e);
      end
      if (rsp_valid && rsp_ready) begin
        if (q.size() == 0) begin
          check("rsp_extra", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          check("rsp", {rsp_result, rsp_c_out, rsp_z_flag,
                        rsp_tag, rsp_div0, rsp_illegal}, e);
        end
      end
    end
  end

  always @(posedge clk) begin
    if (rnd_phase) begin
      #1;
      if (rnd_phase) rsp_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic send(logic [7:0] a, logic [7:0] b, logic [2:0] op,
                      logic cin, logic [TAG_W-1:0] tag);
    bit ok;
    ok = 0;
    cmd_a = a;
    cmd_b = b;
    cmd_op = op;
    cmd_cin = cin;
    cmd_tag = tag;
    cmd_valid = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (cmd_ready) begin
        ok = 1;
        break;
      end
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    if (!ok) check("send_to", 32'd0, 32'd1);
  endtask

  task automatic wait_rsp();
    bit ok;
    ok = 0;
    for (int n = 0; n < 50; n++) begin
      @(posedge clk);
      #1;
      if (rsp_valid) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check("rsp_to", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int n = 0; n < 300; n++) begin
      @(posedge clk);
      #1;
      if (!busy && q.size() == 0) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check("idle_to", 32'd0, 32'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int acc;
    bit stale;
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_a = '0;
    cmd_b = '0;
    cmd_op = '0;
    cmd_cin = 1'b0;
    cmd_tag = '0;
    rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(cmd_ready), 32'd1);
    check("rst_alu_a", 32'(alu_a), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Latency and ADD carry
    rsp_ready = 1'b1;
    send(8'd200, 8'd100, 3'd0, 1'b1, 4'd3);
    repeat (2) @(posedge clk);
    #1;
    check("lat_early", 32'(rsp_valid), 32'd0);
    @(posedge clk);
    #1;
    check("lat_e3", 32'(rsp_valid), 32'd1);
    check("add_res", 32'(rsp_result), 32'h012D);
    check("add_c", 32'(rsp_c_out), 32'd1);
    check("add_z", 32'(rsp_z_flag), 32'd0);
    check("add_tag", 32'(rsp_tag), 32'd3);
    wait_idle();

    send(8'd5, 8'd7, 3'd1, 1'b0, 4'd1);
    wait_rsp();
    check("sub_res", 32'(rsp_result), 32'hFFFE);
    check("sub_c", 32'(rsp_c_out), 32'd1);
    check("sub_z", 32'(rsp_z_flag), 32'd0);
    wait_idle();

    send(8'd255, 8'd255, 3'd2, 1'b0, 4'd2);
    wait_rsp();
    check("mul_res", 32'(rsp_result), 32'hFE01);
    check("mul_c", 32'(rsp_c_out), 32'd0);
    wait_idle();

    send(8'd10, 8'd0, 3'd3, 1'b0, 4'd4);
    wait_rsp();
    check("div0_res", 32'(rsp_result), 32'd0);
    check("div0_z", 32'(rsp_z_flag), 32'd1);
    check("div0_flag", 32'(rsp_div0), 32'd1);
    check("div0_ill", 32'(rsp_illegal), 32'd0);
    wait_idle();

    send(8'd1, 8'd1, 3'd7, 1'b0, 4'd5);
    wait_rsp();
    check("ill_flag", 32'(rsp_illegal), 32'd1);
    check("ill_res", 32'(rsp_result), 32'd0);
    check("ill_z", 32'(rsp_z_flag), 32'd1);
    check("ill_div0", 32'(rsp_div0), 32'd0);
    wait_idle();

    send(8'hF0, 8'h3C, 3'd4, 1'b0, 4'd6);
    send(8'hF0, 8'h3C, 3'd5, 1'b0, 4'd7);
    send(8'd100, 8'd7, 3'd3, 1'b0, 4'd8);
    wait_idle();

    // Back-pressure: six offered, five fit
    rsp_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      cmd_a = 8'(i * 17 + 1);
      cmd_b = 8'(i + 2);
      cmd_op = 3'(i % 6);
      cmd_cin = 1'(i);
      cmd_tag = 4'(i + 8);
      cmd_valid = 1'b1;
      @(negedge clk);
      if (cmd_ready) acc++;
      @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0;
    check("bp_acc", 32'(acc), 32'd5);
    check("bp_ready", 32'(cmd_ready), 32'd0);
    check("bp_count", 32'(fifo_count), 32'd4);
    repeat (5) @(posedge clk);
    #1;
    check("bp_hold_v", 32'(rsp_valid), 32'd1);
    check("bp_hold_tag", 32'(rsp_tag), 32'd8);
    check("bp_hold_cnt", 32'(fifo_count), 32'd4);
    rsp_ready = 1'b1;
    wait_idle();

    // Simultaneous push and pop at count 2
    rsp_ready = 1'b0;
    send(8'h20, 8'd1, 3'd0, 1'b0, 4'd1);
    send(8'h21, 8'd2, 3'd0, 1'b0, 4'd2);
    send(8'h22, 8'd3, 3'd0, 1'b0, 4'd3);
    wait_rsp();
    check("pp_pre_cnt", 32'(fifo_count), 32'd2);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    cmd_a = 8'h23;
    cmd_b = 8'd4;
    cmd_op = 3'd0;
    cmd_cin = 1'b0;
    cmd_tag = 4'd4;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    check("pp_count", 32'(fifo_count), 32'd2);
    check("pp_head", 32'(alu_a), 32'h21);
    wait_idle();

    // Reset while in WAIT with two queued
    send(8'd11, 8'd1, 3'd0, 1'b0, 4'd9);
    send(8'd12, 8'd2, 3'd1, 1'b0, 4'd10);
    send(8'd13, 8'd3, 3'd2, 1'b0, 4'd11);
    check("rw_pre_cnt", 32'(fifo_count), 32'd2);
    rst_n = 1'b0;
    q.delete();
    #1;
    check("rw_count", 32'(fifo_count), 32'd0);
    check("rw_valid", 32'(rsp_valid), 32'd0);
    check("rw_busy", 32'(busy), 32'd0);
    check("rw_alu_a", 32'(alu_a), 32'd0);
    check("rw_res", 32'(rsp_result), 32'd0);
    check("rw_tag", 32'(rsp_tag), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    stale = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (rsp_valid || busy) stale = 1;
    end
    check("rw_stale", 32'(stale), 32'd0);

    // Random traffic with random back-pressure
    rnd_phase = 1;
    for (int i = 0; i < 16; i++)
      send(8'($urandom), 8'($urandom_range(0, 3) == 0 ? 0 : $urandom),
           3'($urandom_range(0, 7)), 1'($urandom), 4'(i));
    rnd_phase = 0;
    @(posedge clk);
    #2;
    rsp_ready = 1'b1;
    wait_idle();
    check("sb_empty", 32'(q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
